// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: turns a one-cycle-latency FIFO read port into a
// full-throughput valid/ready stream with frame tagging and a delivered-word count.
module fifo_rd_stream #(
    parameter int          data_width = 8,
    parameter int          frame_len  = 4,
    parameter logic [15:0] count_init = 16'h0000
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [data_width-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [15:0]           word_count
);

    localparam logic [15:0] last_idx = 16'(frame_len - 1);

    logic [data_width-1:0] mem [3];
    logic [1:0]            rd_ptr;
    logic [1:0]            wr_ptr;
    logic [1:0]            occ;
    logic                  pending;
    logic                  push;
    logic                  pop;
    logic [15:0]           fcnt;
    logic [2:0]            credit_used;

    // Stream handshake: a word transfers on the rising edge where m_valid && m_ready;
    // once m_valid is high it stays high and m_data/m_last hold until that transfer.
    assign credit_used = {1'b0, occ} + {2'b00, pending};
    assign fifo_rd_en  = enable && !fifo_empty && !rd_rst && (credit_used < 3'd3);
    assign push        = pending;
    assign pop         = m_valid && m_ready;
    assign m_valid     = (occ != 2'd0);
    assign m_data      = mem[rd_ptr];
    assign m_last      = m_valid && (fcnt == last_idx);

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            pending    <= 1'b0;
            occ        <= 2'd0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            fcnt       <= 16'd0;
            word_count <= count_init;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            pending <= fifo_rd_en;
            // The credit rule reserves a slot for every issued read, so a push never overflows.
            if (push) begin
                mem[wr_ptr] <= fifo_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr     <= ptr_next(rd_ptr);
                fcnt       <= (fcnt == last_idx) ? 16'd0 : fcnt + 16'd1;
                word_count <= word_count + 16'd1;
            end
            if (push && !pop) begin
                occ <= occ + 2'd1;
            end else if (pop && !push) begin
                occ <= occ - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: behavioural FIFO source, scoreboard on the
// stream side, cycle tables for reset/latency and frame tagging, plus corner sequences.
module tb_fifo_rd_stream;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rd_rst;
    logic          enable;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data;
    logic          fifo_rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [15:0]   word_count;

    logic          enable2;
    logic          fifo_empty2;
    logic [W-1:0]  fifo_data2;
    logic          fifo_rd_en2;
    logic [W-1:0]  m_data2;
    logic          m_valid2;
    logic          m_ready2;
    logic          m_last2;
    logic [15:0]   word_count2;

    always #5 clk = ~clk;

    fifo_rd_stream #(.data_width(W), .frame_len(4)) dut (
        .rd_clk(clk), .rd_rst(rd_rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .word_count(word_count)
    );

    fifo_rd_stream #(.data_width(W), .frame_len(1), .count_init(16'hFFFE)) dut2 (
        .rd_clk(clk), .rd_rst(rd_rst), .enable(enable2), .fifo_empty(fifo_empty2),
        .fifo_data(fifo_data2), .fifo_rd_en(fifo_rd_en2), .m_data(m_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_last(m_last2), .word_count(word_count2)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] data_log[$];
    logic         last_log[$];
    int           cyc_log[$];
    logic         hold_empty = 1'b0;
    int           cyc = 0;

    int           load2  = 0;
    int           taken2 = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [W-1:0] d);
        src_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rd_rst = 1'b1;
        repeat (2) @(negedge clk);
        rd_rst = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && src_q.size() == 0 && !m_valid) begin
                ok = 1;
                break;
            end
        end
        check({name, "_drain_done"}, ok, 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO read port model: data appears the cycle after an accepted read
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (src_q.size() > 0) begin
                fifo_data <= src_q.pop_front();
            end else begin
                checks++;
                failures++;
                $display("FAIL fifo_underflow read issued while source empty at %0t", $time);
            end
        end
        if (fifo_rd_en2) begin
            fifo_data2 <= 8'(8'h50 + taken2);
            taken2     <= taken2 + 1;
        end
    end

    always @(negedge clk) begin
        #1;
        fifo_empty  = (src_q.size() == 0) || hold_empty;
        fifo_empty2 = (taken2 >= load2);
    end

    // Scoreboard monitor for the main instance
    int           model_wc   = 0;
    int           model_fcnt = 0;
    int           issued     = 0;
    int           accepted   = 0;
    logic         held       = 1'b0;
    logic [W-1:0] held_data;

    always @(negedge clk) begin
        #2;
        if (rd_rst) begin
            model_wc   = 0;
            model_fcnt = 0;
            issued     = 0;
            accepted   = 0;
            held       = 1'b0;
        end else begin
            check("word_count", int'(word_count), model_wc & 16'hFFFF);
            if (held) begin
                check("hold_valid", int'(m_valid), 1);
                check("hold_data", int'(m_data), int'(held_data));
            end
            held = 1'b0;
            if (fifo_rd_en) issued++;
            if (m_valid) begin
                check("m_last", int'(m_last), (model_fcnt == 3) ? 1 : 0);
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=0x%0h required=none at %0t", m_data, $time);
                    end else begin
                        check("m_data", int'(m_data), int'(exp_q.pop_front()));
                    end
                    data_log.push_back(m_data);
                    last_log.push_back(m_last);
                    cyc_log.push_back(cyc);
                    accepted++;
                    model_wc++;
                    model_fcnt = (model_fcnt == 3) ? 0 : model_fcnt + 1;
                end else begin
                    held      = 1'b1;
                    held_data = m_data;
                end
            end
            check("in_flight_le3", ((issued - accepted) <= 3) ? 1 : 0, 1);
        end
    end

    typedef struct {
        logic        ready;
        logic        rd_en;
        logic        valid;
        logic [15:0] wc;
    } lat_vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } frame_vec_t;

    typedef struct {
        logic         rd_en;
        logic         valid;
        logic [W-1:0] data;
        logic         last;
        logic [15:0]  wc;
    } wrap_vec_t;

    lat_vec_t   lat_tbl[8];
    frame_vec_t frame_tbl[16];
    wrap_vec_t  wrap_tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int reads;
        int n;
        int ok;

        lat_tbl = '{
            '{1'b1, 1'b1, 1'b0, 16'd0}, '{1'b1, 1'b1, 1'b0, 16'd0},
            '{1'b1, 1'b1, 1'b1, 16'd0}, '{1'b1, 1'b1, 1'b1, 16'd1},
            '{1'b1, 1'b1, 1'b1, 16'd2}, '{1'b1, 1'b0, 1'b1, 16'd3},
            '{1'b1, 1'b0, 1'b1, 16'd4}, '{1'b1, 1'b0, 1'b0, 16'd5}
        };
        for (int i = 0; i < 16; i++) begin
            frame_tbl[i].data = 8'(i + 1);
            frame_tbl[i].last = ((i % 4) == 3);
        end
        wrap_tbl = '{
            '{1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFE}, '{1'b1, 1'b0, 8'h00, 1'b0, 16'hFFFE},
            '{1'b1, 1'b1, 8'h50, 1'b1, 16'hFFFE}, '{1'b0, 1'b1, 8'h51, 1'b1, 16'hFFFF},
            '{1'b0, 1'b1, 8'h52, 1'b1, 16'h0000}, '{1'b0, 1'b0, 8'h00, 1'b0, 16'h0001}
        };

        rd_rst     = 1'b1;
        enable     = 1'b0;
        m_ready    = 1'b0;
        enable2    = 1'b0;
        m_ready2   = 1'b0;
        fifo_empty = 1'b1;
        fifo_empty2 = 1'b1;

        // Reset with five words waiting; reads must stay off until release
        for (int i = 1; i <= 5; i++) push_word(8'(8'hA0 + i));
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check("rst_rd_en", int'(fifo_rd_en), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data", int'(m_data), 0);
        check("rst_m_last", int'(m_last), 0);
        check("rst_word_count", int'(word_count), 0);
        @(negedge clk);
        rd_rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            m_ready = lat_tbl[c].ready;
            #3;
            check($sformatf("lat_rd_en_c%0d", c), int'(fifo_rd_en), int'(lat_tbl[c].rd_en));
            check($sformatf("lat_valid_c%0d", c), int'(m_valid), int'(lat_tbl[c].valid));
            check($sformatf("lat_wc_c%0d", c), int'(word_count), int'(lat_tbl[c].wc));
        end
        wait_drain(50, "lat");

        // Sixteen-word stream at full rate, frame tagging every fourth word
        do_reset();
        data_log.delete();
        last_log.delete();
        cyc_log.delete();
        @(negedge clk);
        for (int i = 0; i < 16; i++) push_word(frame_tbl[i].data);
        wait_drain(200, "frame");
        check("frame_count", data_log.size(), 16);
        if (data_log.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("frame_data_%0d", i), int'(data_log[i]), int'(frame_tbl[i].data));
                check($sformatf("frame_last_%0d", i), int'(last_log[i]), int'(frame_tbl[i].last));
            end
            check("frame_throughput", cyc_log[15] - cyc_log[0], 15);
        end
        check("frame_word_count", int'(word_count), 16);

        // Backpressure: eight queued words, ready low for six cycles
        do_reset();
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(8'(8'hB0 + i));
        reads = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #3;
            if (fifo_rd_en) reads++;
            if (c >= 2) begin
                check($sformatf("bp_valid_c%0d", c), int'(m_valid), 1);
                check($sformatf("bp_data_c%0d", c), int'(m_data), 8'hB1);
            end
        end
        check("bp_reads", reads, 3);
        check("bp_rd_en_off", int'(fifo_rd_en), 0);
        @(negedge clk);
        m_ready = 1'b1;
        wait_drain(100, "bp");
        check("bp_word_count", int'(word_count), 8);

        // Random ready and bursty empty over 1000 words
        n = 0;
        for (int c = 0; c < 20000 && n < 1000; c++) begin
            @(negedge clk);
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) hold_empty = !hold_empty;
            if ($urandom_range(0, 3) != 0) begin
                push_word(8'(n));
                n++;
            end
        end
        check("rand_pushed", n, 1000);
        @(negedge clk);
        hold_empty = 1'b0;
        m_ready    = 1'b1;
        wait_drain(2000, "rand");

        // enable drops while a read is in flight: that word still arrives, no new reads
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) push_word(8'(8'hC0 + i));
        #3;
        check("en_first_read", int'(fifo_rd_en), 1);
        @(negedge clk);
        enable = 1'b0;
        #3;
        check("en_off_rd_en_0", int'(fifo_rd_en), 0);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            #3;
            check($sformatf("en_off_rd_en_%0d", c), int'(fifo_rd_en), 0);
        end
        check("en_pending_delivered", exp_q.size(), 3);
        check("en_idle_valid", int'(m_valid), 0);
        @(negedge clk);
        enable = 1'b1;
        wait_drain(100, "en");

        // frame_len = 1 instance starting at 0xFFFE: count wraps through zero
        do_reset();
        @(negedge clk);
        enable2  = 1'b1;
        m_ready2 = 1'b1;
        load2    = taken2 + 3;
        ok = 1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #3;
            check($sformatf("wrap_rd_en_c%0d", c), int'(fifo_rd_en2), int'(wrap_tbl[c].rd_en));
            check($sformatf("wrap_valid_c%0d", c), int'(m_valid2), int'(wrap_tbl[c].valid));
            check($sformatf("wrap_last_c%0d", c), int'(m_last2), int'(wrap_tbl[c].last));
            check($sformatf("wrap_wc_c%0d", c), int'(word_count2), int'(wrap_tbl[c].wc));
            if (wrap_tbl[c].valid)
                check($sformatf("wrap_data_c%0d", c), int'(m_data2), int'(wrap_tbl[c].data));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
